vcpu_regfile: RTL and testbench
===============================

Name: vcpu_regfile

Overview:
- Parametrised integer register file for the VCPU core. It replaces the core's discrete D0–D7, A0–A6, USP/ISP/MSP registers.
- Provides NRD registered read ports and one sized write port.
- Provides one address-adjust port for (An)+ / -(An) updates.
- Banks the stack pointer (USP/ISP/MSP) by supervisor/master mode.
- Sits between decode (indices) and the execute/EA units (data).

Parameters:
- DATA_W, 32: register width; must be at least 16.
- N_DREG, 8: number of data registers.
- N_AREG, 8: number of address registers. The last one, A(N_AREG-1), is the banked SP.
- NRD, 2: number of read ports.
- ADJ_W, 5: width of the signed adjust delta.
- ISP_RESET, 0: reset value of ISP.
- Derived: NREG = N_DREG + N_AREG + 1 (the extra index is explicit USP); IDX_W = clog2(NREG).

Ports:
- in_CLK  in  1  clock.
- in_RESET  in  1  reset; synchronous, active-high.
- sr_s  in  1  supervisor bit.
- sr_m  in  1  master bit.
- rd_idx  in  NRD*IDX_W  read indices, flattened; port k occupies bits [k*IDX_W +: IDX_W].
- rd_data  out  NRD*DATA_W  read data, flattened the same way.
- wr_en  in  1  write strobe.
- wr_idx  in  IDX_W  write index.
- wr_size  in  2  write size: 00 byte, 01 word, 10 long, 11 reserved.
- wr_data  in  DATA_W  write data.
- wr_err  out  1  one-cycle pulse on an illegal write.
- adj_en  in  1  adjust strobe.
- adj_idx  in  clog2(N_AREG)  address register number.
- adj_delta  in  ADJ_W  signed delta.
- sp_active  out  DATA_W  current active SP value, registered.

Behaviour:
- Reset (in_RESET=1 at a clock edge):
  - All Dn, An, USP, MSP become 0; ISP becomes ISP_RESET.
  - rd_data, sp_active, wr_err become 0.
  - Reset overrides any write or adjust in the same cycle.
- Index map:
  - 0..N_DREG-1 → Dn.
  - N_DREG..N_DREG+N_AREG-2 → A0..A(N_AREG-2).
  - N_DREG+N_AREG-1 → active SP.
  - N_DREG+N_AREG → USP, regardless of mode.
  - Indices ≥ NREG read as 0; writes to them are ignored and raise wr_err.
- Active SP selection: s=0 → USP; s=1,m=0 → ISP; s=1,m=1 → MSP. Decided from the sr_s/sr_m values sampled at the same edge as the access.
- Reads:
  - One-cycle latency: rd_idx sampled at edge N, rd_data valid after edge N.
  - Write-through: the result includes the write and/or adjust committed at edge N, so no stale read exists.
- Write to a Dn:
  - byte replaces [7:0]; word replaces [15:0]; long replaces the full width.
  - Untouched bits are kept.
- Write to an An or SP:
  - word sign-extends wr_data[15:0]; long writes the full width.
  - byte is illegal: no write, wr_err=1 for one cycle.
- wr_size=11 to any register: no write, wr_err=1.
- Adjust:
  - A[adj_idx] ← A[adj_idx] + sext(adj_delta), modulo 2^DATA_W (wraps silently).
  - If adj_idx targets the SP and adj_delta = ±1, the delta applied is ±2 (keeps SP word-aligned).
- Collision: when wr_en and adj_en target the same physical register in one cycle, the write wins and the adjust is dropped. Different registers both commit.
- Mode change and SP access in the same cycle: the access uses the new sr_s/sr_m. No other register is affected by a mode change.
- sp_active: registered copy of the SP selected by mode, including same-edge updates. Latency 1.

Decomposition:
- Shared package vcpu_pkg:
  - size encoding constants SZ_BYTE, SZ_WORD, SZ_LONG, SZ_RSVD;
  - SP select enum SP_USP, SP_ISP, SP_MSP;
  - index helper functions (sp_index, usp_index);
  - merge function for sized writes.
- Sub-module vcpu_sp_bank: holds USP/ISP/MSP, decodes the mode, applies writes and adjusts to the banked pointer, and outputs the active SP.

Test Plan:
- Reset with ISP_RESET=32'h0000_0400, s=1, m=0 → sp_active=0x400; every rd_data=0; wr_err=0.
- D3=0x12345678, then byte write 0xAB → D3=0x123456AB. Word write 0x8000 to A2 → A2=0xFFFF8000. Byte write to A2 → A2 unchanged, wr_err pulses exactly one cycle.
- s=0: write 0x1000 to index SP (USP). Then s=1, m=1: write 0x2000 (MSP). Then m=0 → sp_active=ISP; read index USP → 0x1000. Set m=1 → sp_active=0x2000.
- A7 (SP, ISP)=0x100 with adj_delta=-1 → 0xFE. A1=0xFFFFFFFF with delta=+1 → 0x00000000 (wrap). A1=0 with delta=-8 → 0xFFFFFFF8.
- Same cycle: wr long 0x55 to A4 and adjust A4 by +4 → A4=0x55. Read of A4 sampled that cycle returns 0x55 on the next cycle.
- Write in progress with in_RESET=1 on the same edge → target register is 0 and no wr_err. Also cover an out-of-range index → read returns 0, write raises wr_err.

Source files
------------

// File: rtl/vcpu_pkg.sv
// Shared definitions for the VCPU integer register file: size codes, stack
// pointer bank select, index helpers and the sized-write merge.
package vcpu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_WORD = 2'b01;
  localparam logic [1:0] SZ_LONG = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    SP_USP = 2'd0,
    SP_ISP = 2'd1,
    SP_MSP = 2'd2
  } sp_sel_e;

  // Mode bits to banked stack pointer: user, interrupt or master.
  function automatic sp_sel_e sp_select(input logic s, input logic m);
    if (!s) return SP_USP;
    if (!m) return SP_ISP;
    return SP_MSP;
  endfunction

  // Register index that aliases the active stack pointer.
  function automatic int unsigned sp_index(input int unsigned n_dreg, input int unsigned n_areg);
    return n_dreg + n_areg - 1;
  endfunction

  // Register index that always addresses USP, whatever the mode.
  function automatic int unsigned usp_index(input int unsigned n_dreg,
                                            input int unsigned n_areg);
    return n_dreg + n_areg;
  endfunction

  // Low 16 bits of a data-register write; a long write replaces everything upstream.
  function automatic logic [15:0] merge16(input logic [15:0] old_v, input logic [15:0] new_v,
                                          input logic [1:0] size);
    return (size == SZ_BYTE) ? {old_v[15:8], new_v[7:0]} : new_v;
  endfunction

endpackage

// File: rtl/vcpu_sp_bank.sv
// Banked stack pointer: holds USP/ISP/MSP, selects the active one from the
// mode bits and applies writes and adjusts to it.
module vcpu_sp_bank
  import vcpu_pkg::*;
#(
  parameter int unsigned       DATA_W    = 32,
  parameter logic [DATA_W-1:0] ISP_RESET = '0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_sr_s,
  input  logic              i_sr_m,
  input  logic              i_wr_act,
  input  logic              i_wr_usp,
  input  logic [DATA_W-1:0] i_wr_value,
  input  logic              i_adj_en,
  input  logic [DATA_W-1:0] i_adj_delta,
  output logic [DATA_W-1:0] o_act_nxt,
  output logic [DATA_W-1:0] o_usp_nxt,
  output logic [DATA_W-1:0] o_sp_active
);

  logic [DATA_W-1:0] r_usp, r_isp, r_msp, r_sp_active;
  logic [DATA_W-1:0] w_usp, w_isp, w_msp;
  sp_sel_e           w_sel;

  assign w_sel = sp_select(i_sr_s, i_sr_m);

  // Next pointer values: adjust first, so a write to the same pointer wins.
  always_comb begin
    w_usp = r_usp;
    w_isp = r_isp;
    w_msp = r_msp;
    if (i_adj_en) begin
      case (w_sel)
        SP_USP:  w_usp = r_usp + i_adj_delta;
        SP_ISP:  w_isp = r_isp + i_adj_delta;
        default: w_msp = r_msp + i_adj_delta;
      endcase
    end
    if (i_wr_act) begin
      case (w_sel)
        SP_USP:  w_usp = i_wr_value;
        SP_ISP:  w_isp = i_wr_value;
        default: w_msp = i_wr_value;
      endcase
    end
    if (i_wr_usp) w_usp = i_wr_value;
  end

  // Active pointer after this edge's updates, for write-through reads.
  always_comb begin
    case (w_sel)
      SP_USP:  o_act_nxt = w_usp;
      SP_ISP:  o_act_nxt = w_isp;
      default: o_act_nxt = w_msp;
    endcase
  end

  // Pointer state and registered active-SP copy.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_usp       <= '0;
      r_isp       <= ISP_RESET;
      r_msp       <= '0;
      r_sp_active <= '0;
    end else begin
      r_usp       <= w_usp;
      r_isp       <= w_isp;
      r_msp       <= w_msp;
      r_sp_active <= o_act_nxt;
    end
  end

  assign o_usp_nxt   = w_usp;
  assign o_sp_active = r_sp_active;

endmodule

// File: rtl/vcpu_regfile.sv
// VCPU integer register file: Dn, An and banked SP with registered
// write-through read ports, one sized write port and one adjust port.
module vcpu_regfile
  import vcpu_pkg::*;
#(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       N_DREG    = 8,
  parameter int unsigned       N_AREG    = 8,
  parameter int unsigned       NRD       = 2,
  parameter int unsigned       ADJ_W     = 5,
  parameter logic [DATA_W-1:0] ISP_RESET = '0,
  localparam int unsigned      IDX_W     = $clog2(N_DREG + N_AREG + 1),
  localparam int unsigned      AIDX_W    = $clog2(N_AREG)
) (
  input  logic                  in_CLK,
  input  logic                  in_RESET,
  input  logic                  sr_s,
  input  logic                  sr_m,
  input  logic [NRD*IDX_W-1:0]  rd_idx,
  output logic [NRD*DATA_W-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [1:0]            wr_size,
  input  logic [DATA_W-1:0]     wr_data,
  output logic                  wr_err,
  input  logic                  adj_en,
  input  logic [AIDX_W-1:0]     adj_idx,
  input  logic [ADJ_W-1:0]      adj_delta,
  output logic [DATA_W-1:0]     sp_active
);

  localparam int unsigned NREG     = N_DREG + N_AREG + 1;
  localparam int unsigned SP_IDX   = sp_index(N_DREG, N_AREG);
  localparam int unsigned USP_IDX  = usp_index(N_DREG, N_AREG);
  localparam int unsigned N_APLAIN = N_AREG - 1;

  logic [DATA_W-1:0]     r_d [N_DREG];
  logic [DATA_W-1:0]     w_d [N_DREG];
  logic [DATA_W-1:0]     r_a [N_APLAIN];
  logic [DATA_W-1:0]     w_a [N_APLAIN];
  logic [NRD*DATA_W-1:0] r_rd_data, w_rd_data;
  logic                  r_wr_err, w_wr_illegal;
  logic [DATA_W-1:0]     w_aval, w_delta, w_sp_delta, w_act_nxt, w_usp_nxt;
  logic                  w_wr_act, w_wr_usp, w_sp_adj;

  assign w_aval  = (wr_size == SZ_LONG) ? wr_data : DATA_W'($signed(wr_data[15:0]));
  assign w_delta = DATA_W'($signed(adj_delta));
  // A +-1 step on SP becomes +-2 so the stack stays word-aligned.
  assign w_sp_delta = (adj_delta == ADJ_W'(1) || adj_delta == {ADJ_W{1'b1}}) ?
                      (w_delta << 1) : w_delta;

  // Write/adjust decode; the write is applied last so it wins a collision.
  always_comb begin
    w_d          = r_d;
    w_a          = r_a;
    w_wr_act     = 1'b0;
    w_wr_usp     = 1'b0;
    w_sp_adj     = 1'b0;
    w_wr_illegal = 1'b0;
    if (adj_en) begin
      if (adj_idx == AIDX_W'(N_AREG - 1)) w_sp_adj = 1'b1;
      for (int i = 0; i < N_APLAIN; i++) begin
        if (adj_idx == AIDX_W'(i)) w_a[i] = r_a[i] + w_delta;
      end
    end
    if (wr_en) begin
      w_wr_illegal = (wr_size == SZ_RSVD) || ({1'b0, wr_idx} >= (IDX_W + 1)'(NREG));
      for (int i = 0; i < N_DREG; i++) begin
        if (wr_idx == IDX_W'(i) && wr_size != SZ_RSVD) begin
          w_d[i][15:0] = merge16(r_d[i][15:0], wr_data[15:0], wr_size);
          if (wr_size == SZ_LONG) w_d[i] = wr_data;
        end
      end
      for (int i = 0; i < N_APLAIN; i++) begin
        if (wr_idx == IDX_W'(N_DREG + i)) begin
          if (wr_size == SZ_BYTE) w_wr_illegal = 1'b1;
          else if (wr_size != SZ_RSVD) w_a[i] = w_aval;
        end
      end
      if (wr_idx == IDX_W'(SP_IDX) || wr_idx == IDX_W'(USP_IDX)) begin
        if (wr_size == SZ_BYTE) begin
          w_wr_illegal = 1'b1;
        end else if (wr_size != SZ_RSVD) begin
          w_wr_act = (wr_idx == IDX_W'(SP_IDX));
          w_wr_usp = (wr_idx == IDX_W'(USP_IDX));
        end
      end
    end
  end

  vcpu_sp_bank #(
    .DATA_W   (DATA_W),
    .ISP_RESET(ISP_RESET)
  ) u_sp_bank (
    .i_clk      (in_CLK),
    .i_reset    (in_RESET),
    .i_sr_s     (sr_s),
    .i_sr_m     (sr_m),
    .i_wr_act   (w_wr_act),
    .i_wr_usp   (w_wr_usp),
    .i_wr_value (w_aval),
    .i_adj_en   (w_sp_adj),
    .i_adj_delta(w_sp_delta),
    .o_act_nxt  (w_act_nxt),
    .o_usp_nxt  (w_usp_nxt),
    .o_sp_active(sp_active)
  );

  // Read mux over next-state values, so same-edge commits are visible.
  always_comb begin
    w_rd_data = '0;
    for (int k = 0; k < NRD; k++) begin
      for (int i = 0; i < N_DREG; i++) begin
        if (rd_idx[k*IDX_W +: IDX_W] == IDX_W'(i)) w_rd_data[k*DATA_W +: DATA_W] = w_d[i];
      end
      for (int i = 0; i < N_APLAIN; i++) begin
        if (rd_idx[k*IDX_W +: IDX_W] == IDX_W'(N_DREG + i)) begin
          w_rd_data[k*DATA_W +: DATA_W] = w_a[i];
        end
      end
      if (rd_idx[k*IDX_W +: IDX_W] == IDX_W'(SP_IDX)) w_rd_data[k*DATA_W +: DATA_W] = w_act_nxt;
      if (rd_idx[k*IDX_W +: IDX_W] == IDX_W'(USP_IDX)) w_rd_data[k*DATA_W +: DATA_W] = w_usp_nxt;
    end
  end

  // Register state, read data and the error pulse.
  always_ff @(posedge in_CLK) begin
    if (in_RESET) begin
      for (int i = 0; i < N_DREG; i++) r_d[i] <= '0;
      for (int i = 0; i < N_APLAIN; i++) r_a[i] <= '0;
      r_rd_data <= '0;
      r_wr_err  <= 1'b0;
    end else begin
      r_d       <= w_d;
      r_a       <= w_a;
      r_rd_data <= w_rd_data;
      r_wr_err  <= w_wr_illegal;
    end
  end

  assign rd_data = r_rd_data;
  assign wr_err  = r_wr_err;

endmodule

// File: tb/tb_vcpu_regfile.sv
// Self-checking bench for vcpu_regfile: directed scenarios plus random
// traffic compared every cycle against a register-level model.
module tb_vcpu_regfile;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned N_DREG  = 8;
  localparam int unsigned N_AREG  = 8;
  localparam int unsigned NRD     = 2;
  localparam int unsigned ADJ_W   = 5;
  localparam int unsigned IDX_W   = 5;
  localparam int unsigned AIDX_W  = 3;
  localparam logic [31:0] ISP_RST = 32'h0000_0400;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  sr_s, sr_m;
  logic [NRD*IDX_W-1:0]  rd_idx;
  logic [NRD*DATA_W-1:0] rd_data;
  logic                  wr_en;
  logic [IDX_W-1:0]      wr_idx;
  logic [1:0]            wr_size;
  logic [DATA_W-1:0]     wr_data;
  logic                  wr_err;
  logic                  adj_en;
  logic [AIDX_W-1:0]     adj_idx;
  logic [ADJ_W-1:0]      adj_delta;
  logic [DATA_W-1:0]     sp_active;

  always #5 clk = ~clk;

  vcpu_regfile #(
    .DATA_W   (DATA_W),
    .N_DREG   (N_DREG),
    .N_AREG   (N_AREG),
    .NRD      (NRD),
    .ADJ_W    (ADJ_W),
    .ISP_RESET(ISP_RST)
  ) dut (
    .in_CLK   (clk),
    .in_RESET (rst),
    .sr_s     (sr_s),
    .sr_m     (sr_m),
    .rd_idx   (rd_idx),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_size  (wr_size),
    .wr_data  (wr_data),
    .wr_err   (wr_err),
    .adj_en   (adj_en),
    .adj_idx  (adj_idx),
    .adj_delta(adj_delta),
    .sp_active(sp_active)
  );

  int checks = 0;
  int errors = 0;

  // Model storage: 0-7 D0-D7, 8-14 A0-A6, 15 USP, 16 ISP, 17 MSP.
  logic [31:0] m_reg [18];
  logic [31:0] e_rd  [NRD];
  logic [31:0] e_sp;
  logic        e_err;
  bit          chk_en = 1'b0;

  function automatic int phys(input int idx, input logic s, input logic m);
    if (idx < 15) return idx;
    if (idx == 15) return !s ? 15 : (!m ? 16 : 17);
    if (idx == 16) return 15;
    return -1;
  endfunction

  function automatic bit wr_illegal(input int wp, input logic [1:0] sz);
    return (wp < 0) || (sz == 2'b11) || (wp >= 8 && sz == 2'b00);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one clock edge's worth of architectural effects to the model.
  task automatic model_step();
    logic [31:0] nxt [18];
    logic [31:0] d, delta;
    int wp, ap, p;
    bit wr_ok;
    if (rst) begin
      foreach (m_reg[i]) m_reg[i] = '0;
      m_reg[16] = ISP_RST;
      foreach (e_rd[k]) e_rd[k] = '0;
      e_sp  = '0;
      e_err = 1'b0;
      return;
    end
    nxt   = m_reg;
    e_err = 1'b0;
    wr_ok = 1'b0;
    wp    = -1;
    if (wr_en) begin
      wp = phys(int'(wr_idx), sr_s, sr_m);
      if (wr_illegal(wp, wr_size)) begin
        e_err = 1'b1;
      end else begin
        wr_ok = 1'b1;
        d     = wr_data;
        if (wp < 8) begin
          case (wr_size)
            2'b00:   nxt[wp] = {m_reg[wp][31:8], d[7:0]};
            2'b01:   nxt[wp] = {m_reg[wp][31:16], d[15:0]};
            default: nxt[wp] = d;
          endcase
        end else begin
          nxt[wp] = (wr_size == 2'b01) ? {{16{d[15]}}, d[15:0]} : d;
        end
      end
    end
    if (adj_en) begin
      ap    = (adj_idx == 3'd7) ? phys(15, sr_s, sr_m) : 8 + int'(adj_idx);
      delta = {{27{adj_delta[4]}}, adj_delta};
      if (adj_idx == 3'd7 && (delta == 32'd1 || delta == 32'hFFFF_FFFF)) delta = delta << 1;
      if (!(wr_ok && wp == ap)) nxt[ap] = m_reg[ap] + delta;
    end
    m_reg = nxt;
    for (int k = 0; k < NRD; k++) begin
      p = phys(int'(rd_idx[k*IDX_W +: IDX_W]), sr_s, sr_m);
      e_rd[k] = (p < 0) ? 32'd0 : m_reg[p];
    end
    e_sp = m_reg[phys(15, sr_s, sr_m)];
  endtask

  // Every cycle: DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NRD; k++) begin
        check($sformatf("rd%0d", k), rd_data[k*DATA_W +: DATA_W], e_rd[k]);
      end
      check("sp_active", sp_active, e_sp);
      check("wr_err", {31'd0, wr_err}, {31'd0, e_err});
    end
  end

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_wr(input int idx, input logic [1:0] sz, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_idx  = IDX_W'(idx);
    wr_size = sz;
    wr_data = d;
    cycle();
    wr_en = 1'b0;
  endtask

  task automatic do_adj(input int idx, input int delta);
    adj_en    = 1'b1;
    adj_idx   = AIDX_W'(idx);
    adj_delta = ADJ_W'(delta);
    cycle();
    adj_en = 1'b0;
  endtask

  task automatic set_rd(input int k, input int idx);
    rd_idx[k*IDX_W +: IDX_W] = IDX_W'(idx);
  endtask

  initial begin
    int wp, ap;
    rst = 1'b1; sr_s = 1'b1; sr_m = 1'b0; rd_idx = '0;
    wr_en = 1'b0; wr_idx = '0; wr_size = 2'b00; wr_data = '0;
    adj_en = 1'b0; adj_idx = '0; adj_delta = '0;

    // Reset state, then ISP visible once out of reset.
    cycle();
    chk_en = 1'b1;
    check("rst_sp", sp_active, 32'd0);
    check("rst_rd0", rd_data[31:0], 32'd0);
    check("rst_err", {31'd0, wr_err}, 32'd0);
    rst = 1'b0;
    cycle();
    check("isp_reset", sp_active, 32'h0000_0400);
    check("idle_rd1", rd_data[63:32], 32'd0);

    // Sized writes to D3 and A2.
    set_rd(0, 3);
    do_wr(3, 2'b10, 32'h1234_5678);
    do_wr(3, 2'b00, 32'h0000_00AB);
    check("d3_byte", rd_data[31:0], 32'h1234_56AB);
    check("model_d3", m_reg[3], 32'h1234_56AB);
    set_rd(0, 10);
    do_wr(10, 2'b01, 32'h0000_8000);
    check("a2_word_sext", rd_data[31:0], 32'hFFFF_8000);
    do_wr(10, 2'b00, 32'h0000_0011);
    check("a2_byte_err", {31'd0, wr_err}, 32'd1);
    check("a2_byte_keep", rd_data[31:0], 32'hFFFF_8000);
    cycle();
    check("a2_err_pulse", {31'd0, wr_err}, 32'd0);

    // Stack pointer banking.
    sr_s = 1'b0;
    do_wr(15, 2'b10, 32'h0000_1000);
    sr_s = 1'b1; sr_m = 1'b1;
    do_wr(15, 2'b10, 32'h0000_2000);
    sr_m = 1'b0;
    set_rd(0, 16);
    cycle();
    check("bank_isp", sp_active, 32'h0000_0400);
    check("bank_usp_rd", rd_data[31:0], 32'h0000_1000);
    sr_m = 1'b1;
    cycle();
    check("bank_msp", sp_active, 32'h0000_2000);

    // Adjusts: SP +-1 doubling and wrap-around.
    sr_m = 1'b0;
    set_rd(0, 15);
    do_wr(15, 2'b10, 32'h0000_0100);
    do_adj(7, -1);
    check("sp_adj_m1", rd_data[31:0], 32'h0000_00FE);
    check("sp_adj_act", sp_active, 32'h0000_00FE);
    set_rd(0, 9);
    do_wr(9, 2'b10, 32'hFFFF_FFFF);
    do_adj(1, 1);
    check("a1_wrap", rd_data[31:0], 32'h0000_0000);
    do_adj(1, -8);
    check("a1_neg8", rd_data[31:0], 32'hFFFF_FFF8);
    check("model_a1", m_reg[9], 32'hFFFF_FFF8);

    // Write and adjust colliding on A4.
    set_rd(0, 12);
    wr_en = 1'b1; wr_idx = IDX_W'(12); wr_size = 2'b10; wr_data = 32'h55;
    adj_en = 1'b1; adj_idx = AIDX_W'(4); adj_delta = ADJ_W'(4);
    cycle();
    wr_en = 1'b0; adj_en = 1'b0;
    check("a4_collide", rd_data[31:0], 32'h0000_0055);
    cycle();
    check("a4_hold", rd_data[31:0], 32'h0000_0055);

    // Reset beats a same-edge write.
    do_wr(5, 2'b10, 32'h77);
    set_rd(0, 5);
    rst = 1'b1;
    do_wr(5, 2'b10, 32'hDEAD);
    check("rst_wr_err", {31'd0, wr_err}, 32'd0);
    rst = 1'b0;
    cycle();
    check("rst_wr_d5", rd_data[31:0], 32'd0);

    // Out-of-range indices.
    set_rd(0, 20);
    set_rd(1, 17);
    cycle();
    check("oor_rd20", rd_data[31:0], 32'd0);
    check("oor_rd17", rd_data[63:32], 32'd0);
    do_wr(17, 2'b10, 32'h1);
    check("oor_wr_err", {31'd0, wr_err}, 32'd1);
    do_wr(3, 2'b11, 32'h1);
    check("rsvd_wr_err", {31'd0, wr_err}, 32'd1);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 7) == 0) sr_s = 1'($urandom);
      if ($urandom_range(0, 7) == 0) sr_m = 1'($urandom);
      wr_en     = 1'($urandom);
      wr_idx    = IDX_W'($urandom_range(0, 19));
      wr_size   = 2'($urandom);
      wr_data   = $urandom;
      adj_en    = 1'($urandom);
      adj_idx   = AIDX_W'($urandom);
      adj_delta = ADJ_W'($urandom);
      for (int k = 0; k < NRD; k++) set_rd(k, int'($urandom_range(0, 19)));
      // Keep illegal writes off the register being adjusted.
      wp = phys(int'(wr_idx), sr_s, sr_m);
      ap = (adj_idx == 3'd7) ? phys(15, sr_s, sr_m) : 8 + int'(adj_idx);
      if (wr_en && adj_en && wr_illegal(wp, wr_size) && wp == ap) adj_en = 1'b0;
      cycle();
    end
    rst = 1'b0; wr_en = 1'b0; adj_en = 1'b0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
